// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Per-core pipeline sequencer. Resolves data-memory wait states,
//             taken-branch redirects and load-use hazards into PC / IF/ID /
//             ID/EX / EX/MEM / MEM/WB enables, flush and bubble controls.
//             Keeps saturating stall/flush counters and a sticky memory
//             timeout flag.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,     // IF/ID flush length after a taken branch (1..15)
  parameter int MEM_TIMEOUT  = 255,   // frozen cycles before mem_timeout sets (1..65535)
  parameter int CNT_W        = 32     // performance counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // Down-counter reload value: the branch cycle itself is the first flush cycle.
  localparam logic [3:0]       c_flush_load  = 4'(FLUSH_CYCLES - 1);
  localparam bit               c_multi_flush = (FLUSH_CYCLES > 1);
  localparam logic [15:0]      c_mem_timeout = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  state_t           r_state;
  logic [3:0]       r_flush_left;
  logic [15:0]      r_wait;
  logic             r_lu_prev;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_timeout;

  logic w_freeze;
  logic w_redir_pend;
  logic w_branch;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  // Hazard detection with priority memory wait > branch redirect > load-use.
  // A pending redirect (REDIRECT, or a wait entered from REDIRECT that is
  // now released) keeps flushing IF/ID, which also masks any load-use.
  always_comb begin
    w_freeze     = mem_req & ~mem_ready;
    w_redir_pend = (r_state == ST_REDIRECT) ||
                   ((r_state == ST_MEM_WAIT) && (r_flush_left != 4'd0));
    w_branch     = ex_branch_taken & ~w_freeze;
    w_rs1_hit    = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
    w_rs2_hit    = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
    // r_lu_prev limits a load-use stall to a single cycle.
    w_load_use   = ex_mem_read && (ex_rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit) &&
                   !w_freeze && !w_branch && !w_redir_pend && !r_lu_prev;
  end

  // Combinational pipeline controls; everything is held inactive during reset.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_en      = 1'b0;
    if (!rst && !w_freeze) begin
      pc_en        = ~w_load_use;
      if_id_en     = ~w_load_use;
      pipe_en      = 1'b1;
      if_id_flush  = w_branch | w_redir_pend;
      id_ex_bubble = w_branch | w_load_use;
    end
  end

  // Sequencer FSM and redirect down-counter; the counter is held while frozen
  // so an interrupted redirect resumes once memory releases the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_left <= 4'd0;
    end else if (w_freeze) begin
      r_state <= ST_MEM_WAIT;
    end else if (w_branch) begin
      r_flush_left <= c_multi_flush ? c_flush_load : 4'd0;
      r_state      <= c_multi_flush ? ST_REDIRECT : ST_RUN;
    end else if (w_redir_pend) begin
      r_flush_left <= r_flush_left - 4'd1;
      r_state      <= (r_flush_left == 4'd1) ? ST_RUN : ST_REDIRECT;
    end else begin
      r_state <= ST_RUN;
    end
  end

  // Wait-state counter and sticky timeout flag; the counter saturates at the
  // timeout value and clears as soon as the pipeline is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait        <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else if (w_freeze) begin
      if (r_wait != c_mem_timeout) begin
        r_wait <= r_wait + 16'd1;
      end
      if ((r_wait + 16'd1) == c_mem_timeout) begin
        r_mem_timeout <= 1'b1;
      end
    end else begin
      r_wait <= 16'd0;
    end
  end

  // Remember that a load-use stall was just issued; frozen cycles keep the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lu_prev <= 1'b0;
    end else if (!w_freeze) begin
      r_lu_prev <= w_load_use;
    end
  end

  // Saturating performance counters for stalled cycles and branch redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_branch && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Brief    : Directed self-checking bench for pipeline_hazard_ctrl
//             (FLUSH_CYCLES=3, MEM_TIMEOUT=8, CNT_W=8) with an expected-
//             control scoreboard and small counter/timeout reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int c_cnt_max = 255;
  localparam int c_timeout = 8;

  // Expected control vectors: {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}
  localparam logic [4:0] E_RUN = 5'b11001;
  localparam logic [4:0] E_LU  = 5'b00011;
  localparam logic [4:0] E_BR  = 5'b11111;
  localparam logic [4:0] E_FL  = 5'b11101;
  localparam logic [4:0] E_OFF = 5'b00000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_addr = '0;
  logic [4:0] id_rs2_addr = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] ex_rd_addr = '0;
  logic       ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
  logic [7:0] stall_cnt, flush_cnt;
  logic       mem_timeout;

  int checks   = 0;
  int failures = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  int m_wait   = 0;
  logic m_to   = 1'b0;
  logic [4:0] sb_q[$];

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .MEM_TIMEOUT (8),
    .CNT_W       (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .pipe_en        (pipe_en),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .mem_timeout    (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected controls, compare at the
  // falling edge, then advance the reference counters at the rising edge.
  task automatic step(input string tag, input logic [4:0] r1, input logic ua,
                      input logic [4:0] r2, input logic ub, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mq, input logic my,
                      input logic [4:0] exp);
    logic [4:0] e;
    id_rs1_addr = r1; id_uses_rs1 = ua;
    id_rs2_addr = r2; id_uses_rs2 = ub;
    ex_rd_addr = rd; ex_mem_read = mr; ex_branch_taken = br;
    mem_req = mq; mem_ready = my;
    if (rst) begin
      m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
    end
    sb_q.push_back(exp);
    @(negedge clk);
    e = E_RUN;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, {27'd0, pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}, {27'd0, e});
    end
    chk({tag, "_stall_cnt"}, {24'd0, stall_cnt}, m_stall);
    chk({tag, "_flush_cnt"}, {24'd0, flush_cnt}, m_flush);
    chk({tag, "_mem_timeout"}, {31'd0, mem_timeout}, {31'd0, m_to});
    @(posedge clk);
    if (!rst) begin
      if (!e[4] && m_stall < c_cnt_max) m_stall++;
      if (e == E_BR && m_flush < c_cnt_max) m_flush++;
      if (mq && !my) begin
        m_wait++;
        if (m_wait >= c_timeout) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input string tag, input logic [4:0] exp);
    step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic branch(input string tag, input logic [4:0] exp);
    step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, exp);
  endtask

  task automatic memw(input string tag, input logic my, input logic [4:0] exp);
    step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, my, exp);
  endtask

  initial begin
    // Reset state
    idle("reset", E_OFF);
    rst = 1'b0;
    idle("run_idle", E_RUN);

    // Load-use on rs1 (x5): one stall cycle only, even if the hazard persists
    step("lu_rs1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    chk("stall_after_lu", {24'd0, stall_cnt}, 32'd1);
    step("lu_once", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
    // Load-use on rs2, then non-hazard variants
    step("lu_rs2", 5'd1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    step("rs2_unused", 5'd1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
    step("not_load", 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
    step("load_x0", 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);

    // Taken branch: flush for 3 cycles, bubble for 1
    branch("br", E_BR);
    idle("redir1", E_FL);
    idle("redir2", E_FL);
    idle("redir_done", E_RUN);
    chk("flush_after_br", {24'd0, flush_cnt}, 32'd1);

    // Load-use together with branch: branch wins, flush masks the hazard
    step("lu_br", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E_BR);
    step("lu_in_redir1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_FL);
    step("lu_in_redir2", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_FL);
    idle("lu_br_done", E_RUN);

    // New branch inside REDIRECT reloads the down-counter
    branch("br_a", E_BR);
    idle("br_a_redir", E_FL);
    branch("br_reload", E_BR);
    idle("reload_redir1", E_FL);
    idle("reload_redir2", E_FL);
    idle("reload_done", E_RUN);
    chk("flush_after_reload", {24'd0, flush_cnt}, 32'd4);

    // Reset in the middle of REDIRECT
    branch("br_pre_rst", E_BR);
    rst = 1'b1;
    idle("rst_mid_redir", E_OFF);
    rst = 1'b0;
    idle("after_rst", E_RUN);
    chk("flush_cleared", {24'd0, flush_cnt}, 32'd0);

    // Memory wait of 4 cycles; branch and hazard are masked while frozen
    memw("mem_w1", 1'b0, E_OFF);
    step("mem_w2_br", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_OFF);
    step("mem_w3_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, E_OFF);
    memw("mem_w4", 1'b0, E_OFF);
    memw("mem_ready", 1'b1, E_RUN);
    chk("stall_after_mem", {24'd0, stall_cnt}, 32'd4);
    idle("mem_idle", E_RUN);

    // Timeout: ready withheld 10 cycles, flag sets after 8 and stays
    for (int i = 0; i < 10; i++) memw("to_wait", 1'b0, E_OFF);
    memw("to_ready", 1'b1, E_RUN);
    idle("to_sticky", E_RUN);
    chk("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

    // Stall counter saturation
    for (int i = 0; i < 260; i++) memw("sat_wait", 1'b0, E_OFF);
    memw("sat_ready", 1'b1, E_RUN);
    chk("stall_saturated", {24'd0, stall_cnt}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
